// File: rtl/rr_grant_sel.sv
// rr_grant_sel: 8-requester round-robin arbiter producing a registered grant index
// and valid flag for a downstream 3-to-8 decoder. Every grant is followed by a
// one-cycle gap so the decoded enables never overlap.
//
// Optional build macro RR_FIXED_PRIO_EN: when defined, the rotation pointer is
// removed (tied to 0) and IDLE always grants the lowest-indexed requester.
// Timeout and gap behaviour are the same in both builds.
module rr_grant_sel #(
  parameter int unsigned MAX_TENURE = 16,  // 0 disables the timeout
  parameter int unsigned CNT_W      = 8    // MAX_TENURE must be < 2**CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       expired,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StGrant, StGap} state_e;

  // Last tenure count before a timeout revokes the grant.
  localparam logic [CNT_W-1:0] TenLast = CNT_W'(MAX_TENURE - 1);

  state_e           state;
  logic [CNT_W-1:0] tenure;
  logic [2:0]       ptr;
  logic [2:0]       pick_idx;
  logic [2:0]       cand;
  logic             found;
  logic             withdrew;
  logic             timeout;
  logic             release_grant;

  // First set request at or above ptr, wrapping 7->0 through 3-bit addition.
  always_comb begin
    pick_idx = ptr;
    cand     = ptr;
    found    = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cand = ptr + 3'(k);
      if (!found && req[cand]) begin
        pick_idx = cand;
        found    = 1'b1;
      end
    end
  end

  // Release causes seen while a grant is active.
  always_comb begin
    withdrew      = ~req[gnt_idx];
    timeout       = (MAX_TENURE != 0) && (tenure == TenLast);
    release_grant = (state == StGrant) && (done || withdrew || timeout);
  end

`ifdef RR_FIXED_PRIO_EN
  assign ptr = 3'd0;
`else
  // Rotation pointer moves just past the holder whenever a grant ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 3'd0;
    end else if (release_grant) begin
      ptr <= gnt_idx + 3'd1;
    end
  end
`endif

  // Arbiter FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
      expired   <= 1'b0;
      busy      <= 1'b0;
      tenure    <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          expired <= 1'b0;
          if (|req) begin
            state     <= StGrant;
            gnt_idx   <= pick_idx;
            gnt_valid <= 1'b1;
            busy      <= 1'b1;
            tenure    <= '0;
          end
        end
        StGrant: begin
          if (release_grant) begin
            state     <= StGap;
            gnt_valid <= 1'b0;
            // Timeout only reports when done and withdrawal are both absent.
            expired   <= timeout && !done && !withdrew;
          end else begin
            tenure <= tenure + 1'b1;
          end
        end
        StGap: begin
          state   <= StIdle;
          busy    <= 1'b0;
          expired <= 1'b0;
        end
        default: begin
          state     <= StIdle;
          gnt_valid <= 1'b0;
          busy      <= 1'b0;
          expired   <= 1'b0;
        end
      endcase
    end
  end

endmodule
